sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO with valid/ready handshakes on both sides, occupancy count and programmable almost-full/almost-empty flags. It is the single-clock generation of the crossbar's FIFO storage: it buffers requests and responses between crossbar stages that share one clock, where the asynchronous FIFO's pointer synchronisation is unnecessary. Storage is an internal write-synchronous, read-combinational RAM, so the head word is visible on `pop_data` without extra latency (show-ahead).

## Interface
- `DATA_SIZE`, 32, payload width in bits.
- `ADDR_SIZE`, 3, log2 of depth (≥1).
- `DEPTH`, `1 << ADDR_SIZE`, number of entries (derived, not overridden).
- `AFULL_TH`, `DEPTH-1`, `almost_full` asserts when count ≥ AFULL_TH (1..DEPTH).
- `AEMPTY_TH`, 1, `almost_empty` asserts when count ≤ AEMPTY_TH (0..DEPTH-1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `push_valid`  in  1  write request.
- `push_ready`  out  1  FIFO can accept (= !full).
- `push_data`  in  DATA_SIZE  write payload.
- `pop_valid`  out  1  head word available (= !empty).
- `pop_ready`  in  1  consumer takes head word.
- `pop_data`  out  DATA_SIZE  head word; defined only while `pop_valid`.
- `count`  out  ADDR_SIZE+1  entries held, 0..DEPTH.
- `almost_full`  out  1  count ≥ AFULL_TH.
- `almost_empty`  out  1  count ≤ AEMPTY_TH.
- `overflow`, `underflow`  out  1 each  sticky error flags (only with `SYNC_FIFO_ERR_EN`).

## Operation
- Push fires when `push_valid && push_ready`: write `push_data` at `wptr`, `wptr` +1.
- Pop fires when `pop_valid && pop_ready`: `rptr` +1; `pop_data` is `MEM[rptr]`, combinational.
- Pointers are ADDR_SIZE+1 bits; the low ADDR_SIZE bits address RAM and wrap modulo DEPTH with no special case.
- `count` is a register: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: `count == DEPTH`. Empty: `count == 0`. `push_ready`, `pop_valid`, `almost_full` and `almost_empty` are decoded from registered `count`/pointers. No combinational path from `push_valid` to `pop_valid`, or from `pop_ready` to `push_ready`.
- Simultaneous push and pop with 0 < count < DEPTH: both fire, count unchanged.
- Full: push is refused even if pop fires the same cycle (no push-through).
- Empty: pop is impossible and push does not bypass to `pop_data`.
- Non-handshaked `push_valid` and `pop_ready` are ignored; RAM and pointers are unchanged.
- Reset values: `wptr=rptr=0`, `count=0`, `push_ready=1`, `pop_valid=0`, `almost_full=0` (AFULL_TH ≥ 1), `almost_empty=1`, error flags 0. RAM contents are not reset.
- Reset asserted mid-operation discards all entries immediately (asynchronous). First push is accepted on the first rising edge after `rst` deasserts.

## Timing
- Write-to-read latency: a word pushed at edge N is on `pop_data` with `pop_valid=1` after edge N, i.e. in cycle N+1.
- Pop-to-next-word: after a pop at edge N, the next word appears combinationally in cycle N+1.
- Flags and `count` update on the same edge as the causing handshake.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `SYNC_FIFO_ERR_EN` defined: `overflow` sets on `push_valid && !push_ready`, and `underflow` sets on `pop_ready && !pop_valid`. Both stay set until `rst`. Ports are present.
- `SYNC_FIFO_ERR_EN` undefined: the `overflow` and `underflow` ports and their logic are absent. Refused requests are silently ignored as above.

## Structure
- Package `fifo_pkg`: pointer/count width helper function (`ADDR_SIZE+1`), and a shared `fifo_status_t` struct {full, empty, almost_full, almost_empty} reused by crossbar FIFOs.
- One sub-module `fifo_ram`: DEPTH×DATA_SIZE, write port synchronous on `clk` with enable, read port combinational. Pointer, count and flag logic stay in `sync_fifo`.

## Test plan
- Reset then push 0xA0..0xA7 (DATA_SIZE=32, ADDR_SIZE=3) -> `count` steps 1..8; `push_ready=0` at 8; `almost_full=1` from count 7; pops return 0xA0..0xA7 in order; `almost_empty=1` at count ≤1.
- Full FIFO, push_valid and pop_ready both high for one cycle -> only the pop fires, count 8→7, extra word not written.
- Count 4, continuous push and pop for 20 cycles with incrementing data -> count stays 4, data order preserved across pointer wrap.
- Empty FIFO, pop_ready=1 and push 0x55 -> `pop_valid=0` that cycle; next cycle `pop_data=0x55` and `pop_valid=1`.
- Count 5, assert `rst` between edges -> count=0, `pop_valid=0`, `push_ready=1` immediately; after release, push 0x11 then pop returns 0x11.
- With `SYNC_FIFO_ERR_EN`: push into full -> `overflow=1` held; pop from empty -> `underflow=1`; both clear only on `rst`.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the crossbar FIFOs: pointer/count width and a common status bundle.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Pointers and the occupancy count carry one extra bit so DEPTH itself is representable.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_SIZE storage: synchronous write with enable, combinational read.
// Latency: a write lands on the clock edge, so the word is readable in the following cycle.
module fifo_ram #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [(1<<ADDR_SIZE)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: head word on pop_data with zero latency; push refused when full, no push-through.
// Optional SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags for refused requests.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 3,
  parameter int AFULL_TH  = (1 << ADDR_SIZE) - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [DATA_SIZE-1:0]   push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [DATA_SIZE-1:0]   pop_data,
  output logic [ADDR_SIZE:0]     count,
  output logic                   almost_full,
  output logic                   almost_empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int PW = ptr_width(ADDR_SIZE);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [PW-1:0] wptr, rptr, cnt;
  fifo_status_t  st;
  logic          push_fire, pop_fire;

  // Full/empty come from the wrap bit of the pointers; they track cnt == DEPTH / cnt == 0 exactly.
  always_comb begin
    st              = '0;
    st.empty        = (wptr == rptr);
    st.full         = (wptr == {~rptr[PW-1], rptr[PW-2:0]});
    st.almost_full  = (cnt >= AFULL_C);
    st.almost_empty = (cnt <= AEMPTY_C);
  end

  assign push_ready   = !st.full;
  assign pop_valid    = !st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign count        = cnt;

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_valid && pop_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_fire) wptr <= wptr + 1'b1;
      if (pop_fire)  rptr <= rptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_valid && !push_ready) overflow  <= 1'b1;
      if (pop_ready && !pop_valid)   underflow <= 1'b1;
    end
  end
`endif

  fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wptr[ADDR_SIZE-1:0]),
    .wdata (push_data),
    .raddr (rptr[ADDR_SIZE-1:0]),
    .rdata (pop_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic [3:0]  count;
  logic        almost_full;
  logic        almost_empty;
`ifdef SYNC_FIFO_ERR_EN
  logic        overflow, underflow;
  logic        exp_ovf = 1'b0, exp_unf = 1'b0;
`endif

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_data    (push_data),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .pop_data     (pop_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(q.size()));
    check("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
    check("pop_valid", 32'(pop_valid), 32'(q.size() > 0));
    check("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 1));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
    if (q.size() > 0) check("pop_data", pop_data, q[0]);
`ifdef SYNC_FIFO_ERR_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // Called at a falling edge: drive, check the pre-edge state, then apply the model at the rising edge.
  task automatic step(input logic pv, input logic [31:0] pd, input logic pr);
    bit can_push, can_pop;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    #1;
    check_state();
    can_push = q.size() < DEPTH;
    can_pop  = q.size() > 0;
    @(posedge clk);
`ifdef SYNC_FIFO_ERR_EN
    if (pv && !can_push) exp_ovf = 1'b1;
    if (pr && !can_pop)  exp_unf = 1'b1;
`endif
    if (pr && can_pop)  void'(q.pop_front());
    if (pv && can_push) q.push_back(pd);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    #1;
    check_state();
    rst = 1'b0;
    @(negedge clk);

    // Fill with 0xA0..0xA7, then observe full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0);
    step(1'b0, '0, 1'b0);

    // Full with push and pop together: only the pop may fire.
    step(1'b1, 32'hEE, 1'b1);
    check("no_push_through", 32'(count), 32'd7);
    while (q.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Steady state at count 4 across pointer wrap.
    d = 32'h100;
    for (int i = 0; i < 4; i++) begin step(1'b1, d, 1'b0); d++; end
    for (int i = 0; i < 20; i++) begin step(1'b1, d, 1'b1); d++; end
    check("steady_count", 32'(count), 32'd4);
    while (q.size() > 0) step(1'b0, '0, 1'b1);

    // Empty: no bypass of a same-cycle push to the read side.
    step(1'b1, 32'h55, 1'b1);
    step(1'b0, '0, 1'b0);
    check("after_empty_push", pop_data, 32'h55);
    step(1'b0, '0, 1'b1);

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 1'b0);
    check("pre_reset_count", 32'(count), 32'd5);
    rst = 1'b1;
    #1;
    q.delete();
`ifdef SYNC_FIFO_ERR_EN
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    check_state();
    #1;
    rst = 1'b0;
    step(1'b1, 32'h11, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Random traffic: a filling phase, then a draining phase.
    for (int i = 0; i < 400; i++) begin
      if (i < 200) step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
      else         step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
